// File: rtl/plane_life_ctrl.sv
// Player plane life-cycle sequencer: spawn, play, explosion and game over, timed in frame ticks.
// Optional PLANE_LIFE_CTRL_EXTRA_LIFE_EN adds an extra_life input that awards lives in PLAY/EXPLODE.
//
// state   | meaning
// IDLE    | waiting for first start, plane hidden
// PLAY    | plane flying, invincible while inv_cnt != 0
// EXPLODE | explosion sprite shown for BOOM_TICKS frame ticks
// OVER    | no lives left, waiting for restart
module plane_life_ctrl #(
    parameter int LIVES      = 3,
    parameter int INV_TICKS  = 120,
    parameter int BOOM_TICKS = 30,
    parameter int BLINK_BIT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       boom,
`ifdef PLANE_LIFE_CTRL_EXTRA_LIFE_EN
    input  logic       extra_life,
`endif
    output logic [1:0] state,
    output logic [2:0] lives,
    output logic       invincible,
    output logic       visible,
    output logic       move_en,
    output logic       respawn,
    output logic       exploding,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PLAY    = 2'b01,
        EXPLODE = 2'b10,
        OVER    = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] inv_cnt_q, inv_cnt_d;
    logic [7:0] boom_cnt_q, boom_cnt_d;
    logic       respawn_q, respawn_d;
    logic       hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lives_q    <= 3'(LIVES);
            inv_cnt_q  <= 8'd0;
            boom_cnt_q <= 8'd0;
            respawn_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            inv_cnt_q  <= inv_cnt_d;
            boom_cnt_q <= boom_cnt_d;
            respawn_q  <= respawn_d;
        end
    end

    // A hit only counts against the pre-edge counter value, so the tick that
    // clears invincibility still shields the plane for that cycle.
    assign hit = (state_q == PLAY) && boom && (inv_cnt_q == 8'd0);

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        inv_cnt_d  = inv_cnt_q;
        boom_cnt_d = boom_cnt_q;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d   = PLAY;
                    lives_d   = 3'(LIVES);
                    inv_cnt_d = 8'(INV_TICKS);
                end
            end
            PLAY: begin
                if (tick && inv_cnt_q != 8'd0)
                    inv_cnt_d = inv_cnt_q - 8'd1;
                if (hit) begin
                    state_d    = EXPLODE;
                    boom_cnt_d = 8'(BOOM_TICKS);
                    lives_d    = lives_q - 3'd1;
`ifdef PLANE_LIFE_CTRL_EXTRA_LIFE_EN
                    if (extra_life)
                        lives_d = lives_q;
`endif
                end
            end
            EXPLODE: begin
                if (tick) begin
                    if (boom_cnt_q > 8'd1) begin
                        boom_cnt_d = boom_cnt_q - 8'd1;
                    end else if (boom_cnt_q == 8'd1) begin
                        boom_cnt_d = 8'd0;
                        if (lives_q == 3'd0) begin
                            state_d = OVER;
                        end else begin
                            state_d   = PLAY;
                            inv_cnt_d = 8'(INV_TICKS);
                        end
                    end
                end
            end
        endcase
`ifdef PLANE_LIFE_CTRL_EXTRA_LIFE_EN
        if (extra_life && !hit && lives_q != 3'd7 &&
            (state_q == PLAY || state_q == EXPLODE))
            lives_d = lives_q + 3'd1;
`endif
    end

    assign respawn_d = (state_d == PLAY) && (state_q != PLAY);

    assign state      = state_q;
    assign lives      = lives_q;
    assign respawn    = respawn_q;
    assign move_en    = (state_q == PLAY);
    assign invincible = (state_q == PLAY) && (inv_cnt_q != 8'd0);
    assign visible    = (state_q == PLAY) && ((inv_cnt_q == 8'd0) || inv_cnt_q[BLINK_BIT]);
    assign exploding  = (state_q == EXPLODE);
    assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_plane_life_ctrl.sv
// Directed self-checking bench for plane_life_ctrl with INV_TICKS=16, BOOM_TICKS=4.
// Define PLANE_LIFE_CTRL_EXTRA_LIFE_EN on both files to exercise the extra-life feature.
module tb_plane_life_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       boom = 1'b0;
    logic       extra = 1'b0;
    logic [1:0] state;
    logic [2:0] lives;
    logic       invincible, visible, move_en, respawn, exploding, game_over;

    int n_checks = 0;
    int n_fail   = 0;

    plane_life_ctrl #(
        .LIVES(3), .INV_TICKS(16), .BOOM_TICKS(4), .BLINK_BIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .start(start),
        .boom(boom),
`ifdef PLANE_LIFE_CTRL_EXTRA_LIFE_EN
        .extra_life(extra),
`endif
        .state(state),
        .lives(lives),
        .invincible(invincible),
        .visible(visible),
        .move_en(move_en),
        .respawn(respawn),
        .exploding(exploding),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // drive one cycle of inputs, then leave them low; outputs settle #1 after the edge
    task automatic step(input logic t, input logic b, input logic s, input logic e);
        tick = t; boom = b; start = s; extra = e;
        @(posedge clk);
        #1;
        tick = 1'b0; boom = 1'b0; start = 1'b0; extra = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [7:0] flags();
        return {2'b00, invincible, visible, move_en, respawn, exploding, game_over};
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 8'(state), 8'd0);
        check("rst_lives", 8'(lives), 8'd3);
        check("rst_flags", flags(), 8'h00);
        rst = 1'b0;
        step(0, 0, 0, 0);
        check("idle_hold", 8'(state), 8'd0);
        step(1, 1, 0, 0);
        check("idle_ignores_boom", 8'(state), 8'd0);

        // start: inv=16 -> blink bit clear -> hidden, respawn pulse
        step(0, 0, 1, 0);
        check("start_state", 8'(state), 8'd1);
        check("start_flags", flags(), 8'b0010_1100);
        step(0, 0, 0, 0);
        check("respawn_one_cycle", 8'(respawn), 8'd0);
        step(0, 1, 0, 0);
        check("inv_boom_state", 8'(state), 8'd1);
        check("inv_boom_lives", 8'(lives), 8'd3);
        ticks(1);
        check("blink_inv15", 8'(visible), 8'd1);
        ticks(8);
        check("blink_inv7", 8'(visible), 8'd0);
        ticks(6);
        check("inv1_invincible", 8'(invincible), 8'd1);
        // tick+boom at inv=1: boom shielded
        step(1, 1, 0, 0);
        check("tb_inv1_state", 8'(state), 8'd1);
        check("tb_inv1_lives", 8'(lives), 8'd3);
        check("tb_inv1_flags", flags(), 8'b0001_1000);

        step(0, 1, 0, 0);
        check("boom1_state", 8'(state), 8'd2);
        check("boom1_lives", 8'(lives), 8'd2);
        check("boom1_flags", flags(), 8'b0000_0010);
        step(0, 1, 0, 0);
        check("explode_boom_lives", 8'(lives), 8'd2);
        step(0, 0, 0, 0);
        ticks(3);
        check("explode_3ticks", 8'(state), 8'd2);
        ticks(1);
        check("respawn_state", 8'(state), 8'd1);
        check("respawn_flags", flags(), 8'b0010_1100);
        ticks(15);
        check("reload_inv1", 8'(invincible), 8'd1);
        ticks(1);
        check("reload_inv0", 8'(invincible), 8'd0);

        step(0, 1, 0, 0);
        ticks(4);
        ticks(16);
        check("life2_lives", 8'(lives), 8'd1);
        step(0, 1, 0, 0);
        check("last_boom_lives", 8'(lives), 8'd0);
        ticks(4);
        check("over_state", 8'(state), 8'd3);
        check("over_flags", flags(), 8'b0000_0001);
        check("over_lives", 8'(lives), 8'd0);
        step(1, 1, 0, 0);
        check("over_hold", 8'(state), 8'd3);
        step(0, 0, 1, 0);
        check("restart_state", 8'(state), 8'd1);
        check("restart_lives", 8'(lives), 8'd3);
        check("restart_respawn", 8'(respawn), 8'd1);

        // async reset mid-explosion
        ticks(16);
        step(0, 1, 0, 0);
        check("pre_rst_state", 8'(state), 8'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", 8'(state), 8'd0);
        check("async_rst_lives", 8'(lives), 8'd3);
        check("async_rst_flags", flags(), 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef PLANE_LIFE_CTRL_EXTRA_LIFE_EN
        step(0, 0, 0, 1);
        check("xl_idle", 8'(lives), 8'd3);
        step(0, 0, 1, 0);
        ticks(16);
        step(0, 1, 0, 0);
        ticks(4);
        check("xl_pre", 8'(lives), 8'd2);
        step(0, 0, 0, 1);
        check("xl_play", 8'(lives), 8'd3);
        ticks(16);
        step(0, 1, 0, 1);
        check("xl_boom_lives", 8'(lives), 8'd3);
        check("xl_boom_state", 8'(state), 8'd2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check("xl_to7", 8'(lives), 8'd7);
        step(0, 0, 0, 1);
        check("xl_sat7", 8'(lives), 8'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
